cam_frame_capture: RTL and testbench
====================================

CAM_FRAME_CAPTURE -- requirements
Module: cam_frame_capture

Interface
REQ-001 Parameter DATA_W, default 8, camera data bus width in bits.
REQ-002 Parameter BPP, default 2, bytes per pixel; legal values 1..4.
REQ-003 Parameter H_PIXELS, default 320, pixels per active line.
REQ-004 Parameter V_LINES, default 240, active lines per frame.
REQ-005 Parameter FIFO_DEPTH, default 4, output FIFO depth; power of two, minimum 2.
REQ-006 Parameter SWAP_BYTES, default 0; 0 means the first byte received is the most-significant byte, 1 means it is the least-significant byte.
REQ-007 clk  in  1  system clock; reset  in  1  asynchronous, active-high.
REQ-008 cam_pclk, cam_vsync, cam_href  in  1 each  camera pixel clock, frame sync and line valid; all asynchronous to clk.
REQ-009 cam_data  in  DATA_W  camera byte bus.
REQ-010 enable  in  1  capture enable; single_shot  in  1  stop after one frame; clear_err  in  1  clear sticky error flags.
REQ-011 out_valid  out  1, out_ready  in  1: pixel stream valid/ready handshake.
REQ-012 out_data  out  DATA_W*BPP  assembled pixel.
REQ-013 out_x  out  clog2(H_PIXELS), out_y  out  clog2(V_LINES)  coordinates of out_data.
REQ-014 out_sof  out  1  marks pixel (0,0); out_eol  out  1  marks pixel x=H_PIXELS-1.
REQ-015 frame_done  out  1  one-clk pulse at frame end; frame_count  out  16  count of completed frames.
REQ-016 busy  out  1  high outside IDLE; overflow  out  1 and err_line  out  1  sticky error flags.

Function
REQ-017 cam_pclk, cam_vsync, cam_href and cam_data shall each pass through a 2-flop synchroniser; a pclk event is a synchronised 0->1 transition; cam_pclk shall not exceed clk/4.
REQ-018 On each pclk event, vsync, href and data shall be sampled from the synchronised copies.
REQ-019 States: IDLE, WAIT_VS, ACTIVE, DONE.
REQ-020 IDLE -> WAIT_VS when enable=1; enable=0 in any state -> IDLE on the next clk, partial pixel discarded, FIFO contents preserved.
REQ-021 WAIT_VS -> ACTIVE on a synchronised vsync 1->0 transition; x, y and byte index are cleared at that transition.
REQ-022 In ACTIVE, each pclk event with href=1 shall capture one byte into the byte assembler; after BPP bytes a pixel is complete, byte order per SWAP_BYTES.
REQ-023 A completed pixel shall be written to the FIFO 1 clk after the completing pclk event, together with its x, y, sof and eol.
REQ-024 If the pixel has x>=H_PIXELS or y>=V_LINES, it shall be dropped and no flag set.
REQ-025 If the FIFO is full, the pixel shall be dropped and overflow set; x shall still advance.
REQ-026 On an href 1->0 transition: if byte index!=0 or x!=H_PIXELS, err_line shall be set.
REQ-027 At the same href 1->0 transition, byte index and x shall clear and y shall increment, saturating at V_LINES.
REQ-028 ACTIVE on a vsync 0->1 transition: frame_done pulses 1 clk and frame_count increments, wrapping 0xFFFF->0.
REQ-029 From that transition the next state shall be DONE if single_shot=1, otherwise WAIT_VS.
REQ-030 DONE shall hold until enable=0.
REQ-031 A FIFO transfer occurs when out_valid=1 and out_ready=1; out_valid shall be high whenever the FIFO is non-empty, and out_data/x/y/sof/eol shall be stable while out_valid=1 and out_ready=0.
REQ-032 A simultaneous FIFO write and read when full shall succeed with no overflow.
REQ-033 clear_err=1 clears overflow and err_line; a set event in the same cycle shall take priority.
REQ-034 Latency: a completed pixel shall appear at out_valid no later than 6 clk after cam_pclk rises, given an empty FIFO.

Reset
REQ-035 While reset=1, state shall be IDLE and the FIFO, byte assembler, x, y and synchronisers shall be cleared.
REQ-036 While reset=1, all outputs shall be 0: out_valid, out_data, out_x, out_y, out_sof, out_eol, frame_done, frame_count, busy, overflow and err_line.
REQ-037 Reset asserted mid-frame shall discard all captured data; after release the block shall wait for enable and then a fresh vsync falling edge.

Verification
REQ-038 Full frame, H_PIXELS=4, V_LINES=2, BPP=2, bytes 0x01..0x10, out_ready=1 -> 8 pixels 0x0102..0x0F10, sof on the first, eol on x=3, frame_done pulse, frame_count=1.
REQ-039 SWAP_BYTES=1 with byte pair 0xAB, 0xCD -> out_data=0xCDAB.
REQ-040 out_ready=0 for an entire line with FIFO_DEPTH=4, H_PIXELS=8 -> 4 pixels held, overflow=1, x=4..7 dropped; clear_err -> overflow=0.
REQ-041 href drops after 3 bytes with BPP=2 -> err_line=1, next line starts at x=0, y increments.
REQ-042 single_shot=1 over two frames -> exactly one frame output, state DONE, busy=1 until enable=0.
REQ-043 reset pulse mid-line -> all outputs 0; with enable=1 after release, capture resumes only after the next vsync falling edge.

Source files
------------

// File: rtl/cam_frame_capture.sv
// Parallel-camera frame grabber: resynchronises the camera bus into clk, assembles
// BPP-byte pixels, tags them with (x, y, sof, eol) and queues them on a valid/ready stream.
module cam_frame_capture #(
    parameter int DATA_W     = 8,
    parameter int BPP        = 2,
    parameter int H_PIXELS   = 320,
    parameter int V_LINES    = 240,
    parameter int FIFO_DEPTH = 4,
    parameter int SWAP_BYTES = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cam_pclk,
    input  logic                        cam_vsync,
    input  logic                        cam_href,
    input  logic [DATA_W-1:0]           cam_data,
    input  logic                        enable,
    input  logic                        single_shot,
    input  logic                        clear_err,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W*BPP-1:0]       out_data,
    output logic [$clog2(H_PIXELS)-1:0] out_x,
    output logic [$clog2(V_LINES)-1:0]  out_y,
    output logic                        out_sof,
    output logic                        out_eol,
    output logic                        frame_done,
    output logic [15:0]                 frame_count,
    output logic                        busy,
    output logic                        overflow,
    output logic                        err_line
);
    localparam int PW  = DATA_W * BPP;
    localparam int XW  = $clog2(H_PIXELS);
    localparam int YW  = $clog2(V_LINES);
    localparam int XCW = $clog2(H_PIXELS + 1) + 1;
    localparam int YCW = $clog2(V_LINES + 1);
    localparam int BW  = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE, DONE} state_t;

    typedef struct packed {
        logic [PW-1:0] data;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          sof;
        logic          eol;
    } ent_t;

    state_t state, nstate;

    // Synchronisers; pclk_sync[2] is history for the rising-edge detect.
    logic [2:0]        pclk_sync;
    logic [1:0]        vs_sync, hr_sync;
    logic [DATA_W-1:0] d_sync1, d_sync2;
    logic              vs_q, hr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pclk_sync <= '0;
            vs_sync   <= '0;
            hr_sync   <= '0;
            d_sync1   <= '0;
            d_sync2   <= '0;
        end else begin
            pclk_sync <= {pclk_sync[1:0], cam_pclk};
            vs_sync   <= {vs_sync[0], cam_vsync};
            hr_sync   <= {hr_sync[0], cam_href};
            d_sync1   <= cam_data;
            d_sync2   <= d_sync1;
        end
    end

    logic pclk_ev, vs_fall, vs_rise, hr_fall, byte_ev;
    assign pclk_ev = pclk_sync[1] & ~pclk_sync[2];
    assign vs_fall = pclk_ev & vs_q & ~vs_sync[1];
    assign vs_rise = pclk_ev & ~vs_q & vs_sync[1];
    assign hr_fall = pclk_ev & hr_q & ~hr_sync[1];
    assign byte_ev = pclk_ev & hr_sync[1];

    // vsync/href history is kept in every state so the first edge after arming is seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_q <= 1'b0;
            hr_q <= 1'b0;
        end else if (pclk_ev) begin
            vs_q <= vs_sync[1];
            hr_q <= hr_sync[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state;
        if (!enable) nstate = IDLE;
        else begin
            case (state)
                IDLE:    nstate = WAIT_VS;
                WAIT_VS: if (vs_fall) nstate = ACTIVE;
                ACTIVE:  if (vs_rise) nstate = single_shot ? DONE : WAIT_VS;
                default: nstate = state;
            endcase
        end
    end

    logic active, arm, frame_end;
    always_comb begin
        busy      = (state != IDLE);
        active    = (state == ACTIVE) && enable;
        arm       = (state == WAIT_VS) && enable && vs_fall;
        frame_end = active && vs_rise;
    end

    // Byte assembler and coordinate counters
    logic [PW-1:0]  asm_q, asm_next, pix_data;
    logic [BW-1:0]  bidx, pos;
    logic [XCW-1:0] x, pix_x;
    logic [YCW-1:0] y, pix_y;
    logic           pix_pend;

    always_comb begin
        pos      = (SWAP_BYTES != 0) ? bidx : BW'(BPP - 1) - bidx;
        asm_next = asm_q;
        asm_next[pos*DATA_W +: DATA_W] = d_sync2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_q    <= '0;
            bidx     <= '0;
            x        <= '0;
            y        <= '0;
            pix_pend <= 1'b0;
            pix_data <= '0;
            pix_x    <= '0;
            pix_y    <= '0;
        end else begin
            pix_pend <= 1'b0;
            if (arm) begin
                bidx <= '0;
                x    <= '0;
                y    <= '0;
            end else if (!active) begin
                bidx <= '0;
            end else if (hr_fall) begin
                bidx <= '0;
                x    <= '0;
                if (y != YCW'(V_LINES)) y <= y + 1'b1;
            end else if (byte_ev) begin
                asm_q <= asm_next;
                if (bidx == BW'(BPP - 1)) begin
                    bidx     <= '0;
                    pix_pend <= 1'b1;
                    pix_data <= asm_next;
                    pix_x    <= x;
                    pix_y    <= y;
                    if (x != '1) x <= x + 1'b1;
                end else begin
                    bidx <= bidx + 1'b1;
                end
            end
        end
    end

    // Output FIFO; a write into a full FIFO is allowed when a read frees a slot the same cycle.
    ent_t        mem [FIFO_DEPTH];
    ent_t        wr_ent, head;
    logic [AW:0] wptr, rptr;
    logic        empty, full, rd, wr_req, wr, ovf_set, err_set;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd      = out_valid && out_ready;
    assign wr_req  = pix_pend && (pix_x < XCW'(H_PIXELS)) && (pix_y < YCW'(V_LINES));
    assign wr      = wr_req && (!full || rd);
    assign ovf_set = wr_req && full && !rd;
    assign err_set = active && hr_fall && ((bidx != '0) || (x != XCW'(H_PIXELS)));

    always_comb begin
        wr_ent.data = pix_data;
        wr_ent.x    = pix_x[XW-1:0];
        wr_ent.y    = pix_y[YW-1:0];
        wr_ent.sof  = (pix_x == '0) && (pix_y == '0);
        wr_ent.eol  = (pix_x == XCW'(H_PIXELS - 1));
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr[AW-1:0]] <= wr_ent;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
        end
    end

    assign head = mem[rptr[AW-1:0]];

    always_comb begin
        out_valid = !empty;
        out_data  = out_valid ? head.data : '0;
        out_x     = out_valid ? head.x    : '0;
        out_y     = out_valid ? head.y    : '0;
        out_sof   = out_valid && head.sof;
        out_eol   = out_valid && head.eol;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_done  <= 1'b0;
            frame_count <= '0;
            overflow    <= 1'b0;
            err_line    <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (frame_end) frame_count <= frame_count + 16'd1;
            if (ovf_set)        overflow <= 1'b1;
            else if (clear_err) overflow <= 1'b0;
            if (err_set)        err_line <= 1'b1;
            else if (clear_err) err_line <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cam_frame_capture.sv
// Bench for cam_frame_capture: instance a (H=4, V=2, MSB-first) and instance b
// (H=8, V=2, LSB-first) share the camera bus; only one is enabled at a time.
module tb_cam_frame_capture;
    localparam int DEPTH = 4;
    localparam int VL    = 2;

    typedef struct {
        logic [15:0] d;
        int          x;
        int          y;
        bit          sof;
        bit          eol;
    } px_t;

    logic       clk = 1'b0, reset = 1'b1;
    logic       cam_pclk = 1'b0, cam_vsync = 1'b0, cam_href = 1'b0;
    logic [7:0] cam_data = 8'h00;
    logic [1:0] en = 2'b00;
    logic       single_shot = 1'b0, clear_err = 1'b0, out_ready = 1'b1;

    logic [1:0]  ovalid, osof, oeol, ofd, obusy, oovf, oerr;
    logic [15:0] odata [2];
    logic [15:0] fc [2];
    logic [1:0]  a_x;
    logic [2:0]  b_x;
    logic [0:0]  a_y, b_y;
    logic [31:0] ox [2], oy [2];
    assign ox[0] = 32'(a_x);
    assign ox[1] = 32'(b_x);
    assign oy[0] = 32'(a_y);
    assign oy[1] = 32'(b_y);

    always #5 clk = ~clk;

    cam_frame_capture #(.DATA_W(8), .BPP(2), .H_PIXELS(4), .V_LINES(2),
                        .FIFO_DEPTH(DEPTH), .SWAP_BYTES(0)) dut_a (
        .clk(clk), .reset(reset), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_data(cam_data), .enable(en[0]),
        .single_shot(single_shot), .clear_err(clear_err), .out_valid(ovalid[0]),
        .out_ready(out_ready), .out_data(odata[0]), .out_x(a_x), .out_y(a_y),
        .out_sof(osof[0]), .out_eol(oeol[0]), .frame_done(ofd[0]),
        .frame_count(fc[0]), .busy(obusy[0]), .overflow(oovf[0]), .err_line(oerr[0]));

    cam_frame_capture #(.DATA_W(8), .BPP(2), .H_PIXELS(8), .V_LINES(2),
                        .FIFO_DEPTH(DEPTH), .SWAP_BYTES(1)) dut_b (
        .clk(clk), .reset(reset), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_data(cam_data), .enable(en[1]),
        .single_shot(single_shot), .clear_err(clear_err), .out_valid(ovalid[1]),
        .out_ready(out_ready), .out_data(odata[1]), .out_x(b_x), .out_y(b_y),
        .out_sof(osof[1]), .out_eol(oeol[1]), .frame_done(ofd[1]),
        .frame_count(fc[1]), .busy(obusy[1]), .overflow(oovf[1]), .err_line(oerr[1]));

    int checks = 0, errors = 0;

    // Reference model state
    px_t         q0[$], q1[$];
    logic [15:0] cap0[$], cap1[$];
    logic [7:0]  line_bytes[$];
    int          m_y [2], m_fc [2], m_fd [2], fd_cnt [2];
    bit          m_act [2], m_arm [2], m_ovf [2], m_err [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int h_of(input int t);
        return (t == 0) ? 4 : 8;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pclk_cycle(input logic vs, input logic hr, input logic [7:0] d);
        cam_vsync = vs;
        cam_href  = hr;
        cam_data  = d;
        #40 cam_pclk = 1'b1;
        #40 cam_pclk = 1'b0;
    endtask

    task automatic model_push(input int t, input logic [15:0] d, input int x, input int y);
        px_t p;
        p.d = d; p.x = x; p.y = y;
        p.sof = (x == 0) && (y == 0);
        p.eol = (x == h_of(t) - 1);
        if (t == 0) begin
            if (!out_ready && q0.size() >= DEPTH) m_ovf[0] = 1'b1;
            else q0.push_back(p);
        end else begin
            if (!out_ready && q1.size() >= DEPTH) m_ovf[1] = 1'b1;
            else q1.push_back(p);
        end
    endtask

    task automatic fill(input logic [7:0] start, input int n);
        line_bytes.delete();
        for (int i = 0; i < n; i++) line_bytes.push_back(start + 8'(i));
    endtask

    // One href line; the expected pixel is queued before the pclk edge that completes it.
    task automatic send_line(input int t);
        int          x;
        int          nb;
        logic [15:0] pix;
        x  = 0;
        nb = line_bytes.size();
        for (int i = 0; i < nb; i++) begin
            if (i % 2 == 1) begin
                pix = (t == 1) ? {line_bytes[i], line_bytes[i-1]} : {line_bytes[i-1], line_bytes[i]};
                if (m_act[t] && x < h_of(t) && m_y[t] < VL) model_push(t, pix, x, m_y[t]);
                x++;
            end
            pclk_cycle(1'b0, 1'b1, line_bytes[i]);
        end
        pclk_cycle(1'b0, 1'b0, 8'h00);
        pclk_cycle(1'b0, 1'b0, 8'h00);
        if (m_act[t]) begin
            if (nb % 2 != 0 || x != h_of(t)) m_err[t] = 1'b1;
            if (m_y[t] < VL) m_y[t]++;
        end
    endtask

    task automatic frame_start(input int t);
        pclk_cycle(1'b1, 1'b0, 8'h00);
        pclk_cycle(1'b1, 1'b0, 8'h00);
        m_act[t] = m_arm[t];
        m_y[t]   = 0;
        pclk_cycle(1'b0, 1'b0, 8'h00);
        pclk_cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_end(input int t);
        if (m_act[t]) begin
            m_fc[t] = (m_fc[t] + 1) & 32'hFFFF;
            m_fd[t]++;
            m_act[t] = 1'b0;
            if (single_shot) m_arm[t] = 1'b0;
        end
        pclk_cycle(1'b1, 1'b0, 8'h00);
        pclk_cycle(1'b1, 1'b0, 8'h00);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("drain_within_budget", 32'(n < 500), 32'd1);
        tick(3);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        m_ovf[0] = 1'b0; m_ovf[1] = 1'b0; m_err[0] = 1'b0; m_err[1] = 1'b0;
        tick(1);
        clear_err = 1'b0;
        tick(2);
    endtask

    task automatic chk_flags(input int t, input string tag);
        chk($sformatf("%s_frame_count[%0d]", tag, t), 32'(fc[t]), 32'(m_fc[t]));
        chk($sformatf("%s_frame_done_cycles[%0d]", tag, t), 32'(fd_cnt[t]), 32'(m_fd[t]));
        chk($sformatf("%s_overflow[%0d]", tag, t), 32'(oovf[t]), 32'(m_ovf[t]));
        chk($sformatf("%s_err_line[%0d]", tag, t), 32'(oerr[t]), 32'(m_err[t]));
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int t = 0; t < 2; t++) begin
            chk($sformatf("%s_valid[%0d]", tag, t), 32'(ovalid[t]), 0);
            chk($sformatf("%s_data[%0d]", tag, t), 32'(odata[t]), 0);
            chk($sformatf("%s_x[%0d]", tag, t), ox[t], 0);
            chk($sformatf("%s_y[%0d]", tag, t), oy[t], 0);
            chk($sformatf("%s_sof_eol[%0d]", tag, t), {30'd0, osof[t], oeol[t]}, 0);
            chk($sformatf("%s_frame_done[%0d]", tag, t), 32'(ofd[t]), 0);
            chk($sformatf("%s_frame_count[%0d]", tag, t), 32'(fc[t]), 0);
            chk($sformatf("%s_busy[%0d]", tag, t), 32'(obusy[t]), 0);
            chk($sformatf("%s_flags[%0d]", tag, t), {30'd0, oovf[t], oerr[t]}, 0);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < 2; t++) begin
            m_act[t] = 1'b0; m_fc[t] = 0; m_ovf[t] = 1'b0; m_err[t] = 1'b0; m_y[t] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    // Compare process: every accepted beat against the model, and hold stability under backpressure.
    bit          hold [2];
    logic [15:0] hold_d [2];
    logic [31:0] hold_x [2];
    px_t         e;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                hold[0] = 1'b0;
                hold[1] = 1'b0;
            end else begin
                for (int t = 0; t < 2; t++) begin
                    if (ofd[t]) fd_cnt[t]++;
                    if (hold[t]) begin
                        chk($sformatf("hold_valid[%0d]", t), 32'(ovalid[t]), 1);
                        chk($sformatf("hold_data[%0d]", t), 32'(odata[t]), 32'(hold_d[t]));
                        chk($sformatf("hold_x[%0d]", t), ox[t], hold_x[t]);
                    end
                    if (ovalid[t] && out_ready) begin
                        if ((t == 0 && q0.size() == 0) || (t == 1 && q1.size() == 0)) begin
                            chk($sformatf("unexpected_pixel[%0d]", t), 32'(ovalid[t]), 0);
                        end else begin
                            if (t == 0) begin e = q0.pop_front(); cap0.push_back(odata[0]); end
                            else        begin e = q1.pop_front(); cap1.push_back(odata[1]); end
                            chk($sformatf("data[%0d]", t), 32'(odata[t]), 32'(e.d));
                            chk($sformatf("x[%0d]", t), ox[t], e.x);
                            chk($sformatf("y[%0d]", t), oy[t], e.y);
                            chk($sformatf("sof[%0d]", t), 32'(osof[t]), 32'(e.sof));
                            chk($sformatf("eol[%0d]", t), 32'(oeol[t]), 32'(e.eol));
                        end
                    end
                    hold[t]   = ovalid[t] && !out_ready;
                    hold_d[t] = odata[t];
                    hold_x[t] = ox[t];
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        tick(3);
        chk_reset_outputs("reset");
        reset = 1'b0;

        // Full frame, MSB-first
        tick(2);
        en[0] = 1'b1; m_arm[0] = 1'b1;
        frame_start(0);
        fill(8'h01, 8); send_line(0);
        fill(8'h09, 8); send_line(0);
        frame_end(0);
        wait_drain();
        chk("frame1_pixels", cap0.size(), 8);
        chk("frame1_px0", 32'(cap0[0]), 32'h0102);
        chk("frame1_px3", 32'(cap0[3]), 32'h0708);
        chk("frame1_px4", 32'(cap0[4]), 32'h090A);
        chk("frame1_px7", 32'(cap0[7]), 32'h0F10);
        chk("frame1_count", 32'(fc[0]), 1);
        chk("frame1_done_cycles", 32'(fd_cnt[0]), 1);
        chk("frame1_busy", 32'(obusy[0]), 1);
        chk_flags(0, "frame1");

        // Short line: href drops after 3 bytes
        frame_start(0);
        fill(8'h21, 3); send_line(0);
        fill(8'h31, 8); send_line(0);
        frame_end(0);
        wait_drain();
        chk("shortline_err", 32'(oerr[0]), 1);
        chk("shortline_next_px", 32'(cap0[9]), 32'h3132);
        chk_flags(0, "shortline");
        pulse_clear();
        chk("shortline_cleared", 32'(oerr[0]), 0);

        // Single shot over two frames
        single_shot = 1'b1;
        frame_start(0);
        fill(8'h41, 8); send_line(0);
        fill(8'h49, 8); send_line(0);
        frame_end(0);
        frame_start(0);
        fill(8'h61, 8); send_line(0);
        fill(8'h69, 8); send_line(0);
        frame_end(0);
        wait_drain();
        chk("single_pixels", cap0.size(), 21);
        chk("single_count", 32'(fc[0]), 3);
        chk("single_busy_done", 32'(obusy[0]), 1);
        chk_flags(0, "single");
        en[0] = 1'b0; m_arm[0] = 1'b0; single_shot = 1'b0;
        tick(2);
        chk("single_busy_off", 32'(obusy[0]), 0);

        // LSB-first instance, backpressure over a whole line
        out_ready = 1'b0;
        en[1] = 1'b1; m_arm[1] = 1'b1;
        tick(2);
        frame_start(1);
        fill(8'h03, 14); line_bytes.push_front(8'hCD); line_bytes.push_front(8'hAB);
        send_line(1);
        tick(10);
        chk("bp_valid", 32'(ovalid[1]), 1);
        chk("bp_head", 32'(odata[1]), 32'hCDAB);
        chk("bp_overflow", 32'(oovf[1]), 1);
        chk_flags(1, "bp");
        out_ready = 1'b1;
        wait_drain();
        chk("bp_drained", cap1.size(), 4);
        chk("bp_swap_px0", 32'(cap1[0]), 32'hCDAB);
        chk("bp_swap_px1", 32'(cap1[1]), 32'h0403);
        pulse_clear();
        chk("bp_overflow_cleared", 32'(oovf[1]), 0);
        fill(8'h51, 16); send_line(1);
        frame_end(1);
        wait_drain();
        chk_flags(1, "bp_end");
        en[1] = 1'b0; m_arm[1] = 1'b0;

        // Reset mid-line, then capture only after a fresh vsync fall
        en[0] = 1'b1; m_arm[0] = 1'b1;
        tick(2);
        frame_start(0);
        pclk_cycle(1'b0, 1'b1, 8'h11);
        model_push(0, 16'h1122, 0, 0);
        pclk_cycle(1'b0, 1'b1, 8'h22);
        pclk_cycle(1'b0, 1'b1, 8'h33);
        tick(10);
        reset = 1'b1;
        model_reset();
        tick(2);
        chk_reset_outputs("midreset");
        reset = 1'b0;
        pclk_cycle(1'b0, 1'b1, 8'h44);
        pclk_cycle(1'b0, 1'b1, 8'h55);
        pclk_cycle(1'b0, 1'b0, 8'h00);
        pclk_cycle(1'b0, 1'b0, 8'h00);
        fill(8'hA1, 8); send_line(0);
        tick(5);
        chk("postreset_waiting_busy", 32'(obusy[0]), 1);
        chk("postreset_no_valid", 32'(ovalid[0]), 0);
        frame_start(0);
        fill(8'h71, 8); send_line(0);
        fill(8'h79, 8); send_line(0);
        frame_end(0);
        wait_drain();
        chk("postreset_pixels", cap0.size(), 30);
        chk("postreset_last_px", 32'(cap0[cap0.size()-1]), 32'h7F80);
        chk("postreset_count", 32'(fc[0]), 1);
        chk_flags(0, "postreset");

        chk("model_queue_a_empty", q0.size(), 0);
        chk("model_queue_b_empty", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
